// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the keyboard lines and decodes 11-bit frames.
// Define PS2_BREAK_FILTER_EN to swallow 0xE0/0xF0 prefixes and break codes.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter int unsigned DONE_HOLD      = 2048
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tasta,
    output logic       done,
    output logic       frame_err
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(DONE_HOLD + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic             filt_clk_q, filt_clk_d, filt_prev_q;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TmoW-1:0]  wd_q, wd_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [7:0]       tasta_q, tasta_d;
    logic             err_q, err_d;
    logic             fall, timeout, stop_fall, frame_ok, good_byte, bad, deliver;
`ifdef PS2_BREAK_FILTER_EN
    logic             brk_q, brk_d, ext_q, ext_d;
`endif

    // Filtered clock only flips after FILTER_LEN consecutive samples of the new level.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall    = filt_prev_q & ~filt_clk_q;
    assign timeout = (state_q != StIdle) && !fall && (wd_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (fall && !data_sync_q) state_d = StData;
            StData:   if (fall && bit_cnt_q == 3'd7) state_d = StParity;
            StParity: if (fall) state_d = StStop;
            StStop:   if (fall) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        stop_fall = (state_q == StStop) && fall;
        frame_ok  = data_sync_q && (^{shift_q, par_q});
        good_byte = stop_fall && frame_ok;
        bad       = (stop_fall && !frame_ok) || timeout;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        if (fall) begin
            unique case (state_q)
                StIdle:   bit_cnt_d = '0;
                StData: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                StParity: par_d = data_sync_q;
                default:  ;
            endcase
        end
        if (state_q == StIdle || fall || timeout) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        err_d = bad;
`ifdef PS2_BREAK_FILTER_EN
        deliver = 1'b0;
        brk_d   = brk_q;
        ext_d   = ext_q;
        if (good_byte) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else begin
                deliver = 1'b1;
                ext_d   = 1'b0;
            end
        end
        if (bad) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
`else
        deliver = good_byte;
`endif
        tasta_d = deliver ? shift_q : tasta_q;
        if (deliver) begin
            hold_d = HoldW'(DONE_HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            hold_q      <= '0;
            tasta_q     <= '0;
            err_q       <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
`endif
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_clk_q;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            hold_q      <= hold_d;
            tasta_q     <= tasta_d;
            err_q       <= err_d;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= brk_d;
            ext_q       <= ext_d;
`endif
        end
    end

    assign tasta     = tasta_q;
    assign done      = (hold_q != '0);
    assign frame_err = err_q;

endmodule
